bit_scrambler: RTL and testbench

BIT_SCRAMBLER -- requirements
Module: bit_scrambler

---
 rtl/bit_scrambler.sv | 106 ++++++++++
 tb/tb_bit_scrambler.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/bit_scrambler.sv
// 3GPP Gold-sequence bit scrambler: reseeds x2 from c_init per codeword, fast-forwards NC steps,
// then XORs one sequence bit onto each accepted input bit through a one-deep output register.
module bit_scrambler #(
  parameter int NC      = 1600,
  parameter int CINIT_W = 31
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s_axis_tdata,
  input  logic               s_axis_tvalid,
  input  logic               s_axis_tlast,
  input  logic [CINIT_W-1:0] s_axis_tuser,
  input  logic               eob_in,
  output logic               s_axis_tready,
  output logic               m_axis_tdata,
  output logic               m_axis_tvalid,
  output logic               m_axis_tlast,
  output logic               eob_out,
  input  logic               m_axis_tready
);

  localparam int CNT_W = (NC > 0) ? $clog2(NC + 1) : 1;
  localparam logic [CNT_W-1:0] NC_CNT = CNT_W'(NC);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WARMUP = 2'd1;
  localparam logic [1:0] RUN    = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] warm_cnt;
  logic [30:0]      x1;
  logic [30:0]      x2;
  logic [30:0]      seed;
  logic [30:0]      x1_next;
  logic [30:0]      x2_next;
  logic             accept;
  logic             c_bit;

  // The seed register is always 31 bits; narrower c_init is zero-extended.
  generate
    if (CINIT_W >= 31) begin : g_seed_trunc
      assign seed = s_axis_tuser[30:0];
    end else begin : g_seed_ext
      assign seed = {{(31 - CINIT_W){1'b0}}, s_axis_tuser};
    end
  endgenerate

  assign x1_next = {x1[3] ^ x1[0], x1[30:1]};
  assign x2_next = {x2[3] ^ x2[2] ^ x2[1] ^ x2[0], x2[30:1]};
  assign c_bit   = x1[0] ^ x2[0];

  assign s_axis_tready = (state == RUN) && (!m_axis_tvalid || m_axis_tready);
  assign accept        = s_axis_tvalid && s_axis_tready;

  // NOTE: all state below uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order inside the block.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      warm_cnt      <= '0;
      x1            <= 31'd1;
      x2            <= '0;
      m_axis_tdata  <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      eob_out       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (s_axis_tvalid) begin
            x1       <= 31'd1;
            x2       <= seed;
            warm_cnt <= NC_CNT;
            state    <= (NC > 0) ? WARMUP : RUN;
          end
        end
        WARMUP: begin
          x1 <= x1_next;
          x2 <= x2_next;
          if (warm_cnt != '0) warm_cnt <= warm_cnt - CNT_W'(1);
          if (warm_cnt <= CNT_W'(1)) state <= RUN;
        end
        RUN: begin
          if (accept) begin
            x1 <= x1_next;
            x2 <= x2_next;
            if (s_axis_tlast) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Output register drains independently of the FSM so the last beat of a
      // codeword can still be held or consumed after returning to IDLE.
      if (accept) begin
        m_axis_tdata  <= s_axis_tdata ^ c_bit;
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= s_axis_tlast;
        eob_out       <= eob_in;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bit_scrambler.sv
// Bench for bit_scrambler: a table of NC=0 vectors on a second instance, plus random codewords
// on the default instance compared with a Gold-sequence model built from the raw recurrences.
module tb_bit_scrambler;

  localparam int NC_MAIN = 1600;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Default instance (NC = 1600)
  logic        rst, s_tdata, s_tvalid, s_tlast, eob_i, s_tready;
  logic [30:0] s_tuser;
  logic        m_tdata, m_tvalid, m_tlast, eob_o, m_tready;

  // Second instance with no fast-forward
  logic        z_rst, z_tdata, z_tvalid, z_tlast, z_eob_i, z_tready;
  logic [30:0] z_tuser;
  logic        z_mdata, z_mvalid, z_mlast, z_eob_o, z_mready;

  bit gold[$];

  bit_scrambler #(.NC(NC_MAIN), .CINIT_W(31)) dut (
    .clk(clk), .reset(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tuser(s_tuser), .eob_in(eob_i), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
    .eob_out(eob_o), .m_axis_tready(m_tready)
  );

  bit_scrambler #(.NC(0), .CINIT_W(31)) dut_nc0 (
    .clk(clk), .reset(z_rst),
    .s_axis_tdata(z_tdata), .s_axis_tvalid(z_tvalid), .s_axis_tlast(z_tlast),
    .s_axis_tuser(z_tuser), .eob_in(z_eob_i), .s_axis_tready(z_tready),
    .m_axis_tdata(z_mdata), .m_axis_tvalid(z_mvalid), .m_axis_tlast(z_mlast),
    .eob_out(z_eob_o), .m_axis_tready(z_mready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // c(n) = x1(n+nc) ^ x2(n+nc), each sequence grown term by term from its recurrence
  function automatic void build_gold(input logic [30:0] cinit, input int nc, input int len);
    int total;
    bit x1[];
    bit x2[];
    total = nc + len + 31;
    x1 = new[total];
    x2 = new[total];
    for (int i = 0; i < 31; i++) begin
      x1[i] = (i == 0);
      x2[i] = cinit[i];
    end
    for (int n = 0; n + 31 < total; n++) begin
      x1[n + 31] = x1[n + 3] ^ x1[n];
      x2[n + 31] = x2[n + 3] ^ x2[n + 2] ^ x2[n + 1] ^ x2[n];
    end
    gold.delete();
    for (int n = 0; n < len; n++) gold.push_back(x1[n + nc] ^ x2[n + nc]);
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_s_tready"}, s_tready, 0);
    check({tag, "_m_tvalid"}, m_tvalid, 0);
    check({tag, "_m_tlast"},  m_tlast,  0);
    check({tag, "_m_tdata"},  m_tdata,  0);
    check({tag, "_eob_out"},  eob_o,    0);
  endtask

  // Streams one codeword of random bits. ready_pct sets downstream ready probability;
  // abort_at >= 0 asserts reset once that many beats have been accepted.
  task automatic run_codeword(input string tag, input int len, input logic [30:0] cinit,
                              input int ready_pct, input int abort_at);
    bit data[];
    int idx, out_idx, cyc, budget, extra;
    bit in_hs, out_hs, seen_acc;
    data = new[len];
    foreach (data[i]) data[i] = 1'($urandom_range(1));
    build_gold(cinit, NC_MAIN, len);
    idx = 0; out_idx = 0; cyc = 0; seen_acc = 0;
    budget = len * 8 + NC_MAIN + 200;
    while (out_idx < len) begin
      s_tvalid = (idx < len);
      s_tdata  = (idx < len) ? data[idx] : 1'b0;
      s_tlast  = (idx == len - 1);
      eob_i    = (idx == len - 1);
      s_tuser  = (idx == 0) ? cinit : 31'($urandom);
      m_tready = ($urandom_range(99) < ready_pct);
      @(negedge clk);
      in_hs  = s_tvalid && s_tready;
      out_hs = m_tvalid && m_tready;
      if (in_hs && !seen_acc) begin
        seen_acc = 1;
        check({tag, "_warmup_latency"}, cyc, NC_MAIN + 1);
      end
      if (out_hs) begin
        check($sformatf("%s_data[%0d]", tag, out_idx), m_tdata, data[out_idx] ^ gold[out_idx]);
        check($sformatf("%s_last[%0d]", tag, out_idx), m_tlast, out_idx == len - 1);
        check($sformatf("%s_eob[%0d]",  tag, out_idx), eob_o,   out_idx == len - 1);
        out_idx++;
      end
      @(posedge clk); #1;
      if (in_hs) idx++;
      cyc++;
      if (abort_at >= 0 && idx == abort_at) begin
        rst = 1; s_tvalid = 0;
        @(posedge clk); #1;
        check_reset_state({tag, "_abort"});
        rst = 0;
        extra = 0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          if (m_tvalid) extra++;
        end
        @(posedge clk); #1;
        check({tag, "_abort_no_beats"}, extra, 0);
        return;
      end
      if (cyc > budget) begin
        check({tag, "_timeout_beats"}, out_idx, len);
        break;
      end
    end
    // After the codeword: no stray beats, and the block waits in IDLE
    s_tvalid = 0; s_tlast = 0; eob_i = 0; m_tready = 1;
    extra = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (m_tvalid) extra++;
      if (k == 3) check({tag, "_idle_tready"}, s_tready, 0);
      @(posedge clk); #1;
    end
    check({tag, "_extra_beats"}, extra, 0);
  endtask

  typedef struct {
    bit tdata;
    bit tlast;
    bit eob;
    bit exp_data;
    bit exp_last;
    bit exp_eob;
  } vec_t;

  vec_t vecs[40];

  initial begin
    bit acc;
    int extra;

    rst = 1; s_tdata = 0; s_tvalid = 0; s_tlast = 0; eob_i = 0; s_tuser = '0; m_tready = 1;
    z_rst = 1; z_tdata = 0; z_tvalid = 0; z_tlast = 0; z_eob_i = 0; z_tuser = '0; z_mready = 1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    check("reset_nc0_mvalid", z_mvalid, 0);
    check("reset_nc0_tready", z_tready, 0);
    rst = 0; z_rst = 0;

    // NC = 0, c_init = 0: sequence is 1, thirty 0s, 1, then 0s up to bit 39
    for (int i = 0; i < 40; i++) begin
      vecs[i].tdata    = (i >= 32) ? 1'(i % 2) : 1'b0;
      vecs[i].tlast    = (i == 39);
      vecs[i].eob      = (i == 39);
      vecs[i].exp_data = vecs[i].tdata ^ ((i == 0) || (i == 31));
      vecs[i].exp_last = (i == 39);
      vecs[i].exp_eob  = (i == 39);
    end
    for (int i = 0; i < 40; i++) begin
      z_tvalid = 1; z_tdata = vecs[i].tdata; z_tlast = vecs[i].tlast; z_eob_i = vecs[i].eob;
      z_tuser  = (i == 0) ? 31'd0 : 31'($urandom);
      acc = 0;
      for (int w = 0; w < 10 && !acc; w++) begin
        @(negedge clk);
        acc = z_tready;
        @(posedge clk); #1;
      end
      check($sformatf("nc0_accept[%0d]", i), acc, 1);
      check($sformatf("nc0_valid[%0d]", i), z_mvalid, 1);
      check($sformatf("nc0_data[%0d]", i), z_mdata, vecs[i].exp_data);
      check($sformatf("nc0_last[%0d]", i), z_mlast, vecs[i].exp_last);
      check($sformatf("nc0_eob[%0d]", i), z_eob_o, vecs[i].exp_eob);
    end
    z_tvalid = 0; z_tlast = 0; z_eob_i = 0;
    @(posedge clk); #1;
    check("nc0_valid_clears", z_mvalid, 0);
    check("nc0_idle_tready", z_tready, 0);

    run_codeword("gold256", 256, 31'h1234567, 100, -1);
    run_codeword("bp6144", 6144, 31'($urandom), 50, -1);
    run_codeword("b2b_a", 64, 31'h0ABCDEF, 70, -1);
    run_codeword("b2b_b", 64, 31'h5555AAA, 70, -1);
    run_codeword("single", 1, 31'h7FFFFFFF, 100, -1);
    run_codeword("abort", 300, 31'h1234567, 80, 100);
    run_codeword("after_abort", 128, 31'h1234567, 80, -1);

    // Reset with nothing in flight still leaves the block idle and quiet
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    extra = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (m_tvalid) extra++;
    end
    check("final_quiet", extra, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
